// File: rtl/color_classify_pkg.sv
// color_classify shared definitions.
// Colour codes, filter selects and one-hot FSM states.
package color_classify_pkg;

    // Colour codes as consumed by the core FSM.
    typedef enum logic [1:0] {
        COL_NONE  = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } color_e;

    // Filter selects, packed as {s2, s3}.
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_GREEN = 2'b11;

    // One-hot state bit positions.
    // Settle/gate pairs are adjacent so settle -> gate is a shift.
    localparam int I_IDLE = 0;
    localparam int I_SR   = 1;
    localparam int I_GR   = 2;
    localparam int I_SG   = 3;
    localparam int I_GG   = 4;
    localparam int I_SB   = 5;
    localparam int I_GB   = 6;
    localparam int I_CL   = 7;

    localparam logic [7:0] S_IDLE = 8'b0000_0001;
    localparam logic [7:0] S_SR   = 8'b0000_0010;
    localparam logic [7:0] S_GR   = 8'b0000_0100;
    localparam logic [7:0] S_SG   = 8'b0000_1000;
    localparam logic [7:0] S_GG   = 8'b0001_0000;
    localparam logic [7:0] S_SB   = 8'b0010_0000;
    localparam logic [7:0] S_GB   = 8'b0100_0000;
    localparam logic [7:0] S_CL   = 8'b1000_0000;

endpackage

// File: rtl/color_classify_if.sv
// color_classify sensor/classification bundle.
// master = consumer side, slave = classifier side.
interface color_classify_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             freq_in;
    logic             s2;
    logic             s3;
    logic [1:0]       color;
    logic             frame_done;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] green_cnt;
    logic [CNT_W-1:0] blue_cnt;

    modport master (
        output en, freq_in,
        input  s2, s3, color, frame_done,
        input  red_cnt, green_cnt, blue_cnt
    );

    modport slave (
        input  en, freq_in,
        output s2, s3, color, frame_done,
        output red_cnt, green_cnt, blue_cnt
    );
endinterface

// File: rtl/color_classify_pulse_counter.sv
// Sensor pulse counter: 2-FF sync, rising-edge
// detect, clearable enable-gated saturating count.
module pulse_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freq_in,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] count
);
    logic sync1, sync2, prev;
    logic rise;

    assign rise = sync2 & ~prev;

    // Bring the async sensor output into clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= freq_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Count detected edges while gated; stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (cnt_en && rise && count != '1) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/color_classify.sv
// TCS3200 front end: sequences R/G/B filters, counts
// pulses per channel and emits a debounced colour code.
module color_classify
    import color_classify_pkg::*;
#(
    parameter int SETTLE_CYCLES = 50000,
    parameter int GATE_CYCLES   = 500000,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 200,
    parameter int MARGIN_SHIFT  = 2,
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    color_classify_if.slave bus
);
    localparam int TMAX = (SETTLE_CYCLES > GATE_CYCLES)
                        ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W:0] MIN_C    = (CNT_W+1)'(MIN_COUNT);

    logic [7:0]       state;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] r_hold, g_hold;
    logic [1:0]       cand;
    logic [MW-1:0]    match, nmatch;
    logic             in_settle, in_gate;
    logic             settle_done, gate_done;
    logic [CNT_W:0]   mx, sec;
    color_e           win;
    logic [1:0]       raw;

    assign in_settle = state[I_SR] | state[I_SG] | state[I_SB];
    assign in_gate   = state[I_GR] | state[I_GG] | state[I_GB];
    assign settle_done = in_settle && timer == SET_LAST;
    assign gate_done   = in_gate && timer == GATE_LAST;

    // Shared counter: cleared as each gate opens.
    pulse_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .freq_in (bus.freq_in),
        .clr     (settle_done),
        .cnt_en  (in_gate),
        .count   (count)
    );

    // Filter sequencer; dropping en aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            timer <= '0;
            {bus.s2, bus.s3} <= FILT_RED;
        end else if (!state[I_IDLE] && !state[I_CL]
                     && !bus.en) begin
            state <= S_IDLE;
            timer <= '0;
            {bus.s2, bus.s3} <= FILT_RED;
        end else begin
            timer <= timer + TW'(1);
            unique case (1'b1)
                state[I_IDLE]: begin
                    timer <= '0;
                    if (bus.en) begin
                        state <= S_SR;
                        {bus.s2, bus.s3} <= FILT_RED;
                    end
                end
                state[I_SR], state[I_SG], state[I_SB]: begin
                    if (settle_done) begin
                        state <= state << 1;
                        timer <= '0;
                    end
                end
                state[I_GR]: begin
                    if (gate_done) begin
                        state <= S_SG;
                        timer <= '0;
                        {bus.s2, bus.s3} <= FILT_GREEN;
                    end
                end
                state[I_GG]: begin
                    if (gate_done) begin
                        state <= S_SB;
                        timer <= '0;
                        {bus.s2, bus.s3} <= FILT_BLUE;
                    end
                end
                state[I_GB]: begin
                    if (gate_done) begin
                        state <= S_CL;
                        timer <= '0;
                    end
                end
                state[I_CL]: begin
                    timer <= '0;
                    state <= bus.en ? S_SR : S_IDLE;
                    {bus.s2, bus.s3} <= FILT_RED;
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    {bus.s2, bus.s3} <= FILT_RED;
                end
            endcase
        end
    end

    // Park red/green totals once their gate has closed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
            g_hold <= '0;
        end else begin
            if (state[I_SG] && timer == '0) r_hold <= count;
            if (state[I_SB] && timer == '0) g_hold <= count;
        end
    end

    // Pick winner and runner-up; ties fail the margin.
    always_comb begin
        mx  = '0;
        sec = '0;
        win = COL_NONE;
        if (r_hold >= g_hold && r_hold >= count) begin
            mx  = {1'b0, r_hold};
            sec = {1'b0, (g_hold >= count) ? g_hold : count};
            win = COL_RED;
        end else if (g_hold >= count) begin
            mx  = {1'b0, g_hold};
            sec = {1'b0, (r_hold >= count) ? r_hold : count};
            win = COL_GREEN;
        end else begin
            mx  = {1'b0, count};
            sec = {1'b0, (r_hold >= g_hold) ? r_hold : g_hold};
            win = COL_BLUE;
        end
        raw = (mx >= MIN_C && mx > sec + (sec >> MARGIN_SHIFT))
            ? win : COL_NONE;
    end

    // Match count after this frame's result.
    always_comb begin
        nmatch = MW'(1);
        if (raw == cand) begin
            nmatch = (match == MW'(STABLE_FRAMES))
                   ? match : match + MW'(1);
        end
    end

    // Publish counts and debounce the colour per frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand           <= COL_NONE;
            match          <= '0;
            bus.color      <= COL_NONE;
            bus.frame_done <= 1'b0;
            bus.red_cnt    <= '0;
            bus.green_cnt  <= '0;
            bus.blue_cnt   <= '0;
        end else begin
            bus.frame_done <= state[I_CL];
            if (state[I_CL]) begin
                bus.red_cnt   <= r_hold;
                bus.green_cnt <= g_hold;
                bus.blue_cnt  <= count;
                cand  <= raw;
                match <= nmatch;
                if (nmatch == MW'(STABLE_FRAMES))
                    bus.color <= raw;
            end
        end
    end
endmodule

// File: tb/tb_color_classify.sv
// Directed bench for color_classify with a frame
// scoreboard; a 4-bit twin shares the stimulus.
module tb_color_classify;
    import color_classify_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic freq = 1'b0;

    always #5 clk = ~clk;

    color_classify_if #(.CNT_W(16)) bus ();
    color_classify_if #(.CNT_W(4))  bus4 ();

    assign bus.en       = en;
    assign bus.freq_in  = freq;
    assign bus4.en      = en;
    assign bus4.freq_in = freq;

    color_classify #(
        .SETTLE_CYCLES (10),
        .GATE_CYCLES   (100),
        .CNT_W         (16),
        .MIN_COUNT     (10),
        .MARGIN_SHIFT  (2),
        .STABLE_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    color_classify #(
        .SETTLE_CYCLES (10),
        .GATE_CYCLES   (100),
        .CNT_W         (4),
        .MIN_COUNT     (10),
        .MARGIN_SHIFT  (2),
        .STABLE_FRAMES (2)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        logic [1:0] color;
        int r;
        int g;
        int b;
        int r4;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int t = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            freq = 1'b1;
            step_to(t + 2);
            freq = 1'b0;
            step_to(t + 2);
        end
    endtask

    // Enter at the negedge before SETTLE_R (t=0);
    // leave at t=2 of the following frame.
    task automatic run_frame(input int r, input int g,
                             input int b,
                             input logic [1:0] col);
        exp_t e;
        e.color = col;
        e.r = r;
        e.g = g;
        e.b = b;
        e.r4 = (r > 15) ? 15 : r;
        sb.push_back(e);
        step_to(1);
        check("sel_r_first", {bus.s2, bus.s3}, 2'b00);
        step_to(15);
        pulses(r);
        step_to(110);
        check("sel_r_last", {bus.s2, bus.s3}, 2'b00);
        step_to(111);
        check("sel_g_first", {bus.s2, bus.s3}, 2'b11);
        step_to(125);
        pulses(g);
        step_to(220);
        check("sel_g_last", {bus.s2, bus.s3}, 2'b11);
        step_to(221);
        check("sel_b_first", {bus.s2, bus.s3}, 2'b01);
        step_to(235);
        pulses(b);
        step_to(330);
        check("sel_b_last", {bus.s2, bus.s3}, 2'b01);
        step_to(331);
        check("fd_early", bus.frame_done, 0);
        t = 0;
        step_to(1);
        check("fd_pulse", bus.frame_done, 1);
        e = sb.pop_front();
        check("color", bus.color, e.color);
        check("red_cnt", bus.red_cnt, e.r);
        check("green_cnt", bus.green_cnt, e.g);
        check("blue_cnt", bus.blue_cnt, e.b);
        check("red_cnt_sat4", bus4.red_cnt, e.r4);
        step_to(2);
        check("fd_single", bus.frame_done, 0);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("rst_s2", bus.s2, 0);
        check("rst_s3", bus.s3, 0);
        check("rst_color", bus.color, 0);
        check("rst_fd", bus.frame_done, 0);
        check("rst_red", bus.red_cnt, 0);
        check("rst_blue", bus.blue_cnt, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        en = 1'b1;
        t = 0;
        run_frame(0, 0, 0, 2'd0);
        // red wins, then blue
        run_frame(20, 5, 5, 2'd0);
        run_frame(20, 5, 5, 2'd1);
        run_frame(5, 5, 20, 2'd1);
        run_frame(5, 5, 20, 2'd3);
        // threshold
        run_frame(9, 9, 9, 2'd3);
        run_frame(9, 9, 9, 2'd0);
        run_frame(10, 0, 0, 2'd0);
        run_frame(10, 0, 0, 2'd1);
        // margin and tie
        run_frame(20, 16, 0, 2'd1);
        run_frame(20, 16, 0, 2'd0);
        run_frame(21, 16, 0, 2'd0);
        run_frame(21, 16, 0, 2'd1);
        run_frame(20, 20, 0, 2'd1);
        run_frame(20, 20, 0, 2'd0);
        // one-frame glitch
        run_frame(20, 5, 5, 2'd0);
        run_frame(20, 5, 5, 2'd1);
        run_frame(5, 20, 5, 2'd1);
        run_frame(20, 5, 5, 2'd1);
        run_frame(20, 5, 5, 2'd1);

        // abort during GATE_B
        step_to(15);
        pulses(7);
        step_to(125);
        pulses(5);
        step_to(250);
        check("abort_sel_pre", {bus.s2, bus.s3}, 2'b01);
        en = 1'b0;
        step_to(251);
        check("abort_sel", {bus.s2, bus.s3}, 2'b00);
        seen = 0;
        while (t < 420) begin
            step_to(t + 1);
            if (bus.frame_done) seen++;
        end
        check("abort_no_fd", seen, 0);
        check("abort_color", bus.color, 1);
        check("abort_red_cnt", bus.red_cnt, 20);

        // async reset mid GATE_G
        en = 1'b1;
        t = 0;
        step_to(150);
        check("pre_rst_sel", {bus.s2, bus.s3}, 2'b11);
        check("pre_rst_color", bus.color, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_s2", bus.s2, 0);
        check("mid_rst_s3", bus.s3, 0);
        check("mid_rst_color", bus.color, 0);
        check("mid_rst_fd", bus.frame_done, 0);
        check("mid_rst_red", bus.red_cnt, 0);
        check("mid_rst_green", bus.green_cnt, 0);
        check("mid_rst_blue", bus.blue_cnt, 0);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end
endmodule
